// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE filter-load/compute sequencer: FSM state
// encoding and default sizing of the layer configuration fields.
package pe_ctrl_pkg;

  localparam int DEF_MAX_FILTERNUM   = 64;
  localparam int DEF_MAX_KERNELNUM   = 8;
  localparam int DEF_FILTERNUM_WIDTH = $clog2(DEF_MAX_FILTERNUM) + 1;
  localparam int DEF_KERNELNUM_WIDTH = $clog2(DEF_MAX_KERNELNUM) + 1;
  localparam int DEF_PIX_WIDTH       = 16;
  localparam int DEF_DRAIN_CYCLES    = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching limit-1; last flags that the
// current count is the final one before the wrap.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  assign last = (cnt == (limit - WIDTH'(1)));

  // Count accepted events; clear has priority, wrap on the last value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pe_load_ctrl.sv
// Layer sequencer: latches a configuration on start, streams the filter
// weights into the PE decoder, gates the activation beats, drains the PE
// pipeline and pulses done (with cfg_err for an unusable configuration).
module pe_load_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int MAX_FILTERNUM   = DEF_MAX_FILTERNUM,
  parameter int MAX_KERNELNUM   = DEF_MAX_KERNELNUM,
  parameter int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
  parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
  parameter int PIX_WIDTH       = DEF_PIX_WIDTH,
  parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  input  logic [PIX_WIDTH-1:0]       num_pixel,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic                       act_valid,
  output logic                       act_ready,
  output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
  output logic [KERNELNUM_WIDTH-1:0] kernel_cnt,
  output logic                       filter_load,
  output logic                       pe_en,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

  state_t                       state;
  logic [FILTERNUM_WIDTH-1:0]   cfg_filter;
  logic [KERNELNUM_WIDTH-1:0]   cfg_kernel;
  logic [PIX_WIDTH-1:0]         cfg_pixel;
  logic [PIX_WIDTH-1:0]         pix_cnt;
  logic [DRAIN_W-1:0]           drain_cnt;
  logic                         accept;
  logic                         cfg_bad;
  logic                         w_fire;
  logic                         kernel_last;
  logic                         filter_last;
  logic                         pix_last;

  assign accept  = (state == IDLE) && start;
  assign cfg_bad = (num_filter == '0) || (num_kernel == '0) || (num_pixel == '0) ||
                   (num_filter > FILTERNUM_WIDTH'(MAX_FILTERNUM)) ||
                   (num_kernel > KERNELNUM_WIDTH'(MAX_KERNELNUM));
  assign w_fire  = w_valid && w_ready;
  assign pe_en   = act_valid && act_ready;

  // Capture the layer configuration only when a start is taken in IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_filter <= num_filter;
      cfg_kernel <= num_kernel;
      cfg_pixel  <= num_pixel;
    end
  end

  wrap_counter #(.WIDTH(KERNELNUM_WIDTH)) u_kernel_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (w_fire),
    .limit (cfg_kernel),
    .cnt   (kernel_cnt),
    .last  (kernel_last)
  );

  wrap_counter #(.WIDTH(FILTERNUM_WIDTH)) u_filter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (w_fire && kernel_last),
    .limit (cfg_filter),
    .cnt   (filter_cnt),
    .last  (filter_last)
  );

  wrap_counter #(.WIDTH(PIX_WIDTH)) u_pix_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (pe_en),
    .limit (cfg_pixel),
    .cnt   (pix_cnt),
    .last  (pix_last)
  );

  // Sequencer FSM; every handshake/status output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      w_ready     <= 1'b0;
      act_ready   <= 1'b0;
      filter_load <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_bad) begin
              state   <= DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              state       <= LOAD;
              w_ready     <= 1'b1;
              filter_load <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_fire && kernel_last && filter_last) begin
            state       <= COMPUTE;
            w_ready     <= 1'b0;
            filter_load <= 1'b0;
            act_ready   <= 1'b1;
          end
        end
        COMPUTE: begin
          if (pe_en && pix_last) begin
            state     <= DRAIN;
            act_ready <= 1'b0;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          w_ready     <= 1'b0;
          act_ready   <= 1'b0;
          filter_load <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_load_ctrl.sv
// Scoreboard bench for pe_load_ctrl: stimulus queues the expected weight
// handshakes, pixel handshakes and done pulses; a negedge monitor checks them.
module tb_pe_load_ctrl;
  import pe_ctrl_pkg::*;

  localparam int FW = DEF_FILTERNUM_WIDTH;
  localparam int KW = DEF_KERNELNUM_WIDTH;
  localparam int PW = DEF_PIX_WIDTH;
  localparam int DC = DEF_DRAIN_CYCLES;

  logic          clk;
  logic          reset;
  logic          start;
  logic [FW-1:0] num_filter;
  logic [KW-1:0] num_kernel;
  logic [PW-1:0] num_pixel;
  logic          w_valid;
  logic          w_ready;
  logic          act_valid;
  logic          act_ready;
  logic [FW-1:0] filter_cnt;
  logic [KW-1:0] kernel_cnt;
  logic          filter_load;
  logic          pe_en;
  logic          busy;
  logic          done;
  logic          cfg_err;

  pe_load_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_filter  (num_filter),
    .num_kernel  (num_kernel),
    .num_pixel   (num_pixel),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .filter_cnt  (filter_cnt),
    .kernel_cnt  (kernel_cnt),
    .filter_load (filter_load),
    .pe_en       (pe_en),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  typedef struct { int f; int k; int cyc; } wexp_t;
  typedef struct { int cyc; bit err; } dexp_t;

  wexp_t wq[$];
  int    pq[$];
  dexp_t dq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  wexp_t mw;
  dexp_t md;
  int    mp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s %s", name, detail);
    end
  endfunction

  // Monitor: pop and compare whenever the DUT presents a handshake or done.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_valid && w_ready) begin
        chk(wq.size() > 0, "w_unexpected",
            $sformatf("cyc=%0d got f=%0d k=%0d, required no weight beat", cyc, filter_cnt, kernel_cnt));
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          chk((int'(filter_cnt) == mw.f) && (int'(kernel_cnt) == mw.k) && filter_load &&
              ((mw.cyc < 0) || (cyc == mw.cyc)), "w_beat",
              $sformatf("got f=%0d k=%0d load=%0d cyc=%0d, required f=%0d k=%0d load=1 cyc=%0d",
                        filter_cnt, kernel_cnt, filter_load, cyc, mw.f, mw.k, mw.cyc));
        end
      end
      if (pe_en) begin
        chk(pq.size() > 0, "pix_unexpected", $sformatf("cyc=%0d got pe_en=1, required 0", cyc));
        if (pq.size() > 0) begin
          mp = pq.pop_front();
          chk(!filter_load && !w_ready && ((mp < 0) || (cyc == mp)), "pix_beat",
              $sformatf("got cyc=%0d load=%0d w_ready=%0d, required cyc=%0d load=0 w_ready=0",
                        cyc, filter_load, w_ready, mp));
        end
      end
      if (cfg_err) begin
        chk(done, "cfg_err_alone", $sformatf("got done=%0d with cfg_err, required 1", done));
      end
      if (done) begin
        chk(dq.size() > 0, "done_unexpected", $sformatf("cyc=%0d got done=1, required 0", cyc));
        if (dq.size() > 0) begin
          md = dq.pop_front();
          chk((cfg_err == md.err) && busy && ((md.cyc < 0) || (cyc == md.cyc)), "done_pulse",
              $sformatf("got cyc=%0d cfg_err=%0d busy=%0d, required cyc=%0d cfg_err=%0d busy=1",
                        cyc, cfg_err, busy, md.cyc, md.err));
        end
      end
    end
  end

  // mode 0: valids always high; 1: backpressure; 2: start pulsed again during LOAD
  task automatic run(input string name, input int nf, input int nk, input int np, input int mode);
    int  c;
    bit  legal;
    @(posedge clk); #1;
    num_filter = FW'(nf);
    num_kernel = KW'(nk);
    num_pixel  = PW'(np);
    start      = 1'b1;
    w_valid    = (mode != 1);
    act_valid  = (mode != 1);
    c          = cyc;
    legal = (nf >= 1) && (nf <= DEF_MAX_FILTERNUM) && (nk >= 1) && (nk <= DEF_MAX_KERNELNUM) && (np >= 1);
    if (legal) begin
      for (int f = 0; f < nf; f++)
        for (int k = 0; k < nk; k++)
          wq.push_back('{f, k, (mode == 1) ? -1 : c + 1 + f * nk + k});
      for (int p = 0; p < np; p++)
        pq.push_back((mode == 1) ? -1 : c + 1 + nf * nk + p);
      dq.push_back('{(mode == 1) ? -1 : c + 1 + nf * nk + np + DC, 1'b0});
    end else begin
      dq.push_back('{c + 1, 1'b1});
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      if (mode == 1) begin
        w_valid   = (i % 2 == 0);
        act_valid = (i % 3 != 2);
      end
      if (mode == 2 && i == 2) begin
        start      = 1'b1;
        num_filter = FW'(5);
        num_kernel = KW'(5);
        num_pixel  = PW'(9);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk(!busy, {name, "_finish"}, $sformatf("got busy=%0d, required 0 within bound", busy));
    chk((wq.size() == 0) && (pq.size() == 0) && (dq.size() == 0), {name, "_leftover"},
        $sformatf("got pending w=%0d pix=%0d done=%0d, required 0 0 0", wq.size(), pq.size(), dq.size()));
    wq.delete();
    pq.delete();
    dq.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    chk(!w_ready && !act_ready && !filter_load && !busy && !done && !cfg_err && !pe_en &&
        (filter_cnt == '0) && (kernel_cnt == '0), name,
        $sformatf("got wr=%0d ar=%0d fl=%0d busy=%0d done=%0d err=%0d f=%0d k=%0d, required all 0",
                  w_ready, act_ready, filter_load, busy, done, cfg_err, filter_cnt, kernel_cnt));
  endtask

  initial begin
    int c;
    reset      = 1'b1;
    start      = 1'b0;
    num_filter = '0;
    num_kernel = '0;
    num_pixel  = '0;
    w_valid    = 1'b0;
    act_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    reset = 1'b0;

    run("basic", 2, 3, 4, 0);
    run("backpressure", 2, 3, 4, 1);
    run("max_cfg", 64, 8, 1, 0);
    run("illegal_kernel0", 2, 0, 4, 0);
    run("illegal_filter65", 65, 2, 4, 0);
    run("illegal_pixel0", 1, 1, 0, 0);
    run("start_busy", 2, 3, 4, 2);
    run("single", 1, 1, 1, 0);

    // Reset after three accepted weight beats.
    @(posedge clk); #1;
    num_filter = FW'(2);
    num_kernel = KW'(3);
    num_pixel  = PW'(4);
    start      = 1'b1;
    w_valid    = 1'b1;
    act_valid  = 1'b1;
    c          = cyc;
    for (int k = 0; k < 3; k++) wq.push_back('{0, k, c + 1 + k});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle_outputs("reset_mid_load");
    repeat (5) @(posedge clk);
    #1;
    chk((wq.size() == 0) && (dq.size() == 0) && !busy, "reset_mid_load_quiet",
        $sformatf("got pending w=%0d done=%0d busy=%0d, required 0 0 0", wq.size(), dq.size(), busy));
    wq.delete();

    run("after_reset", 2, 3, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_load_ctrl.md
Name: pe_load_ctrl

Overview:
Sequencer for the PE array filter-load/compute cycle. It accepts a layer configuration on start, streams num_filter × num_kernel weight beats while driving filter_cnt, kernel_cnt and filter_load into the PE decoder, then gates num_pixel activation beats into the array and drains the pipeline. It pulses done when the layer completes. It sits between the top-level layer controller, the weight buffer and the PE decoder/array.

Parameters:
MAX_FILTERNUM, 64, max filters (PEs) per layer
MAX_KERNELNUM, 8, max kernel words per filter
FILTERNUM_WIDTH, $clog2(MAX_FILTERNUM)+1, filter count width
KERNELNUM_WIDTH, $clog2(MAX_KERNELNUM)+1, kernel count width
PIX_WIDTH, 16, pixel count width
DRAIN_CYCLES, 4, PE pipeline flush cycles after last pixel (≥1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  pulse; latches config when IDLE
num_filter  in  FILTERNUM_WIDTH  filters to load, 1..MAX_FILTERNUM
num_kernel  in  KERNELNUM_WIDTH  kernel words per filter, 1..MAX_KERNELNUM
num_pixel  in  PIX_WIDTH  activation beats to compute, ≥1
w_valid  in  1  weight buffer has beat
w_ready  out  1  weight beat accepted when w_valid&w_ready
act_valid  in  1  activation beat present
act_ready  out  1  activation accepted when act_valid&act_ready
filter_cnt  out  FILTERNUM_WIDTH  index of filter being loaded
kernel_cnt  out  KERNELNUM_WIDTH  index of kernel word within filter
filter_load  out  1  1 = load phase, 0 otherwise
pe_en  out  1  PE compute enable (= act_valid&act_ready)
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse with done on an illegal config

Behaviour:
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Moore outputs from registered state/counters; pe_en is the only combinational AND.
- Reset: state=IDLE. All counters, w_ready, act_ready, filter_load, busy, done and cfg_err are 0.
- IDLE: start=1 latches num_filter/num_kernel/num_pixel.
  - If any of them is 0, or num_filter>MAX_FILTERNUM, or num_kernel>MAX_KERNELNUM: go to DONE with cfg_err.
  - Otherwise go to LOAD next cycle.
- start outside IDLE is ignored; the latched config is unchanged.
- LOAD: w_ready=1, filter_load=1. On each accepted beat:
  - kernel_cnt increments.
  - When kernel_cnt==num_kernel-1, kernel_cnt wraps to 0 and filter_cnt increments.
  - The beat with filter_cnt==num_filter-1 and kernel_cnt==num_kernel-1 moves to COMPUTE. filter_cnt and kernel_cnt clear to 0 there.
  - w_valid=0 stalls the counters with no timeout.
- COMPUTE: act_ready=1, filter_load=0, w_ready=0. Each accepted beat increments pix_cnt. The beat with pix_cnt==num_pixel-1 moves to DRAIN.
- DRAIN: a down-counter is loaded with DRAIN_CYCLES-1. The FSM moves to DONE when it reaches 0, giving exactly DRAIN_CYCLES cycles in DRAIN. act_ready=0.
- DONE: one cycle with done=1 (cfg_err=1 if entered via error), then IDLE. busy stays 1 in DONE.
- Latency, legal config, no stalls: start at cycle t gives first w_ready at t+1. With N = num_filter·num_kernel:
  - COMPUTE at t+1+N.
  - DRAIN at t+1+N+num_pixel.
  - done at t+1+N+num_pixel+DRAIN_CYCLES.
- Width rules: all comparisons use the latched config. Counters never exceed their latched limit minus 1; no wrap beyond. The num_filter=MAX_FILTERNUM case fits because the width is clog2+1.
- Reset mid-operation: immediate return to IDLE next edge, counters cleared. Partial loads are discarded with no done pulse.

Decomposition:
- Package pe_ctrl_pkg holds:
  - state encoding (IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, DONE=4, 3 bits);
  - width localparams derived from MAX_FILTERNUM/MAX_KERNELNUM;
  - default DRAIN_CYCLES.
- One natural sub-module: wrap_counter (parameter WIDTH). Inputs: clr, inc, limit. Outputs: cnt and a last flag. It is instantiated for kernel_cnt, filter_cnt and pix_cnt.

Test Plan:
- Basic: num_filter=2, num_kernel=3, num_pixel=4, w_valid/act_valid always 1, start at t0.
  - (filter_cnt,kernel_cnt) sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - COMPUTE at t0+7, 4 pe_en cycles, done at t0+15.
- Backpressure: same config, w_valid toggling 1/0 and act_valid low every 3rd cycle → counters hold on gaps, exactly 6 weight and 4 pixel handshakes, done once.
- Max config: num_filter=64, num_kernel=8, num_pixel=1 → 512 load beats, final filter_cnt=63/kernel_cnt=7 before COMPUTE, no overflow.
- Illegal: start with num_kernel=0 → DONE next cycle, done=1 and cfg_err=1 same cycle, no w_ready ever.
- Start while busy: pulse start with different config during LOAD → ignored, original counts complete.
- Reset mid-LOAD: assert reset after 3 beats → next cycle IDLE, all outputs 0, no done. A new start then runs cleanly from (0,0).
